// File: rtl/bram_port_exerciser_if.sv
// BRAM port bundle between the exerciser (master) and one BRAM port (slave).
// Signal names keep the exerciser's point of view: o_* driven by it, i_rdata returned to it.
interface bram_port_exerciser_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              o_en;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic [DATA_W-1:0] i_rdata;

  modport master (output o_en, output o_we, output o_addr, output o_data, input  i_rdata);
  modport slave  (input  o_en, input  o_we, input  o_addr, input  o_data, output i_rdata);
endinterface

// File: rtl/bram_port_exerciser.sv
// Write/read sweep traffic generator and read-back checker for one BRAM port.
// Optional BRAM_EXER_FAULT_INJ_EN adds i_inject to corrupt the word written at address 0.
module bram_port_exerciser #(
  parameter int unsigned       ADDR_W = 10,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       RD_LAT = 2,
  parameter logic [DATA_W-1:0] SEED   = 32'hA5A5_0000
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wr_req,
  input  logic                  i_rd_req,
`ifdef BRAM_EXER_FAULT_INJ_EN
  input  logic                  i_inject,
`endif
  bram_port_exerciser_if.master bram,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_err_cnt,
  output logic [1:0]            o_led
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);
  localparam logic [15:0]       ERR_MAX    = 16'hFFFF;

  state_t            r_state;
  logic [2:0]        r_wr_sync;
  logic [2:0]        r_rd_sync;
  logic              r_wr_edge;
  logic              r_rd_edge;
  logic [2:0]        r_drain_cnt;
  logic [RD_LAT-1:0] r_pipe_v;
  logic [DATA_W-1:0] r_pipe_e [RD_LAT];

  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_mismatch;
  logic              w_inject;

  assign w_addr_nxt = bram.o_addr + ADDR_W'(1);
  assign w_data_nxt = SEED + DATA_W'(w_addr_nxt);
  assign w_mismatch = r_pipe_v[RD_LAT-1] && (bram.i_rdata != r_pipe_e[RD_LAT-1]);

`ifdef BRAM_EXER_FAULT_INJ_EN
  assign w_inject = i_inject;
`else
  assign w_inject = 1'b0;
`endif

  // Bits [1:0] are the synchroniser, bit [2] the previous level for edge detection;
  // the registered edge pulse gives the raw-edge-to-o_en latency of four clocks.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_sync <= '0;
      r_rd_sync <= '0;
      r_wr_edge <= 1'b0;
      r_rd_edge <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns this chain into a real multi-stage synchroniser.
      r_wr_sync <= {r_wr_sync[1:0], i_wr_req};
      r_rd_sync <= {r_rd_sync[1:0], i_rd_req};
      r_wr_edge <= r_wr_sync[1] & ~r_wr_sync[2];
      r_rd_edge <= r_rd_sync[1] & ~r_rd_sync[2];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      bram.o_en   <= 1'b0;
      bram.o_we   <= 1'b0;
      bram.o_addr <= '0;
      bram.o_data <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err_cnt   <= '0;
      o_led       <= '0;
      r_drain_cnt <= '0;
      r_pipe_v    <= '0;
      for (int j = 0; j < RD_LAT; j++) r_pipe_e[j] <= '0;
    end else begin
      o_done <= 1'b0;
      for (int j = RD_LAT - 1; j > 0; j--) begin
        r_pipe_v[j] <= r_pipe_v[j-1];
        r_pipe_e[j] <= r_pipe_e[j-1];
      end
      r_pipe_v[0] <= 1'b0;

      if (w_mismatch && (o_err_cnt != ERR_MAX)) o_err_cnt <= o_err_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          bram.o_en <= 1'b0;
          bram.o_we <= 1'b0;
          if (r_wr_edge) begin
            r_state     <= S_WRITE;
            bram.o_en   <= 1'b1;
            bram.o_we   <= 1'b1;
            bram.o_addr <= '0;
            bram.o_data <= w_inject ? ~SEED : SEED;
            o_busy      <= 1'b1;
            o_led       <= '0;
          end else if (r_rd_edge) begin
            r_state     <= S_READ;
            bram.o_en   <= 1'b1;
            bram.o_we   <= 1'b0;
            bram.o_addr <= '0;
            o_busy      <= 1'b1;
            o_err_cnt   <= '0;
            o_led       <= '0;
            r_pipe_v[0] <= 1'b1;
            r_pipe_e[0] <= SEED;
          end
        end
        S_WRITE: begin
          if (bram.o_addr == ADDR_MAX) begin
            r_state   <= S_DONE;
            bram.o_en <= 1'b0;
            bram.o_we <= 1'b0;
            o_done    <= 1'b1;
          end else begin
            bram.o_addr <= w_addr_nxt;
            bram.o_data <= w_data_nxt;
          end
        end
        S_READ: begin
          if (bram.o_addr == ADDR_MAX) begin
            r_state     <= S_DRAIN;
            bram.o_en   <= 1'b0;
            r_drain_cnt <= '0;
          end else begin
            bram.o_addr <= w_addr_nxt;
            r_pipe_v[0] <= 1'b1;
            r_pipe_e[0] <= w_data_nxt;
          end
        end
        S_DRAIN: begin
          // The last compare lands on the final drain cycle, so o_err_cnt is settled here.
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
            o_led   <= {o_err_cnt != 16'd0, o_err_cnt == 16'd0};
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
